// File: rtl/cotm32_pkg.sv
// Shared constants and types for the cotm32 terminal UART transmit path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cotm32_pkg;

    localparam int BYTE_WIDTH         = 8;
    // 100 MHz core clock at 115200 baud
    localparam int UART_CLKS_PER_BIT  = 868;
    localparam int UART_TX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the UART serializer.
// Latency: push visible on dout/count the cycle after the write edge; dout is combinational from head.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
module uart_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is data-only and carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer, LSB first, idle-high line.
// Latency: byte pushed into an empty FIFO with the FSM idle drives the start bit two edges later.
// Backpressure: none upstream; a write while full is dropped and flagged by a one-cycle o_overflow.
module uart_tx
    import cotm32_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_TX_FIFO_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic [BYTE_WIDTH-1:0]         i_data,
    output logic                          o_ready,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_tx
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(BYTE_WIDTH + 1);

    uart_tx_state_e          state;
    logic [CW-1:0]           baud_cnt;
    logic [BCW-1:0]          bit_cnt;
    logic [BYTE_WIDTH-1:0]   shift;
    logic [BYTE_WIDTH-1:0]   fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    baud_last;
    logic                    pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_WIDTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (i_valid),
        .pop   (pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign o_ready   = !fifo_full;
    assign o_busy    = (o_count != '0) || (state != IDLE);
    assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // Fetch the next byte when idle, or at the very end of a stop bit so frames abut.
    assign pop       = !fifo_empty &&
                       ((state == IDLE) || ((state == STOP) && baud_last));

    // Shift register loads on pop and advances at the end of each data bit.
    always_ff @(posedge i_clk) begin
        if (pop) begin
            shift <= fifo_dout;
        end else if ((state == DATA) && baud_last) begin
            shift <= shift >> 1;
        end
    end

    // Frame sequencer; o_tx is registered from the current state so it lags state by one edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            o_tx       <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_valid && fifo_full;
            case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (pop) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    o_tx     <= 1'b0;
                    baud_cnt <= baud_last ? '0 : baud_cnt + CW'(1);
                    if (baud_last) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    o_tx     <= shift[0];
                    baud_cnt <= baud_last ? '0 : baud_cnt + CW'(1);
                    if (baud_last) begin
                        if (bit_cnt == BCW'(BYTE_WIDTH - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                STOP: begin
                    o_tx     <= 1'b1;
                    baud_cnt <= baud_last ? '0 : baud_cnt + CW'(1);
                    if (baud_last) begin
                        bit_cnt <= '0;
                        state   <= pop ? START : IDLE;
                    end
                end
                default: begin
                    o_tx  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A line monitor captures each 40-cycle frame and compares it against the expected byte queue.
// Cycle n below means the interval just after the n-th rising edge counted from the push edge (cycle 0).
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_overflow;
    logic       o_busy;
    logic [2:0] o_count;
    logic       o_tx;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         rx_count = 0;
    int         frame_starts[$];
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_overflow (o_overflow),
        .o_busy     (o_busy),
        .o_count    (o_count),
        .o_tx       (o_tx)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then return 1 time unit after the edge that sampled it.
    task automatic step(input logic v, input logic [7:0] d);
        i_valid = v;
        i_data  = d;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int budget;
        budget = 20 * FRAME;
        while (rx_count < n && budget > 0) begin
            step(1'b0, 8'h00);
            budget--;
        end
        chk(tag, 64'(rx_count), 64'(n));
    endtask

    // Line monitor: one full frame of per-cycle samples compared against start/LSB-first data/stop.
    initial begin : monitor
        logic [FRAME-1:0] obs;
        logic [FRAME-1:0] expv;
        logic [7:0]       e;
        int               start;
        int               idx;
        bit               aborted;
        forever begin
            @(posedge i_clk);
            #2;
            if (!i_rst && o_tx === 1'b0) begin
                start   = cyc;
                obs     = '0;
                aborted = 1'b0;
                for (int b = 0; b < FRAME; b++) begin
                    if (b != 0) begin
                        @(posedge i_clk);
                        #2;
                    end
                    if (i_rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    obs[b] = o_tx;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 64'(rx_count + 1), 64'(rx_count));
                    end else begin
                        e = exp_q.pop_front();
                        for (int b = 0; b < FRAME; b++) begin
                            idx = b / CPB;
                            if (idx == 0)      expv[b] = 1'b0;
                            else if (idx == 9) expv[b] = 1'b1;
                            else               expv[b] = e[idx-1];
                        end
                        chk($sformatf("frame_%02h", e), 64'(obs), 64'(expv));
                    end
                    frame_starts.push_back(start);
                    rx_count++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int pcyc;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Reset state
        chk("rst_tx",       64'(o_tx),       64'd1);
        chk("rst_count",    64'(o_count),    64'd0);
        chk("rst_ready",    64'(o_ready),    64'd1);
        chk("rst_busy",     64'(o_busy),     64'd0);
        chk("rst_overflow", 64'(o_overflow), 64'd0);

        // Single byte 0xA5: start bit at cycle 2, busy gone by cycle 42
        base = rx_count;
        exp_q.push_back(8'hA5);
        step(1'b1, 8'hA5);
        pcyc = cyc;
        chk("a5_c0_count", 64'(o_count), 64'd1);
        chk("a5_c0_busy",  64'(o_busy),  64'd1);
        step(1'b0, 8'h00);
        chk("a5_c1_count", 64'(o_count), 64'd0);
        chk("a5_c1_tx",    64'(o_tx),    64'd1);
        repeat (39) step(1'b0, 8'h00);
        chk("a5_c40_busy", 64'(o_busy),  64'd1);
        repeat (2) step(1'b0, 8'h00);
        chk("a5_c42_busy", 64'(o_busy),  64'd0);
        chk("a5_c42_tx",   64'(o_tx),    64'd1);
        chk("a5_frames",   64'(rx_count), 64'(base + 1));
        if (rx_count > base)
            chk("a5_start_cycle", 64'(frame_starts[base]), 64'(pcyc + 2));

        // 0x00 then 0xFF back to back: zero gap between frames
        base = rx_count;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        step(1'b1, 8'h00);
        pcyc = cyc;
        step(1'b1, 8'hFF);
        chk("b2b_c1_count", 64'(o_count), 64'd1);
        wait_frames(base + 2, "b2b_frames");
        if (rx_count >= base + 2) begin
            chk("b2b_start_cycle", 64'(frame_starts[base]), 64'(pcyc + 2));
            chk("b2b_gap", 64'(frame_starts[base+1] - frame_starts[base]), 64'(FRAME));
        end
        repeat (3) step(1'b0, 8'h00);
        chk("b2b_idle_busy", 64'(o_busy), 64'd0);

        // Six bytes on consecutive cycles: sixth dropped with one overflow pulse
        base = rx_count;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        step(1'b1, 8'h01);
        chk("ovf_c0_count", 64'(o_count), 64'd1);
        step(1'b1, 8'h02);
        chk("ovf_c1_count", 64'(o_count), 64'd1);
        step(1'b1, 8'h03);
        chk("ovf_c2_count", 64'(o_count), 64'd2);
        step(1'b1, 8'h04);
        chk("ovf_c3_count", 64'(o_count), 64'd3);
        step(1'b1, 8'h05);
        chk("ovf_c4_count", 64'(o_count), 64'd4);
        chk("ovf_c4_ready", 64'(o_ready), 64'd0);
        chk("ovf_c4_pulse", 64'(o_overflow), 64'd0);
        step(1'b1, 8'h06);
        chk("ovf_c5_pulse", 64'(o_overflow), 64'd1);
        chk("ovf_c5_count", 64'(o_count), 64'd4);
        step(1'b0, 8'h00);
        chk("ovf_c6_pulse", 64'(o_overflow), 64'd0);
        wait_frames(base + 5, "ovf_frames");
        if (rx_count >= base + 5)
            for (int i = 0; i < 4; i++)
                chk($sformatf("ovf_gap%0d", i),
                    64'(frame_starts[base+i+1] - frame_starts[base+i]), 64'(FRAME));
        repeat (2 * FRAME) step(1'b0, 8'h00);
        chk("ovf_no_extra", 64'(rx_count), 64'(base + 5));
        chk("ovf_idle_busy", 64'(o_busy), 64'd0);

        // Push on the exact edge the FSM pops at end of stop bit with three queued
        base = rx_count;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'hC0 + 8'(i));
        step(1'b1, 8'hC1);
        step(1'b0, 8'h00);
        step(1'b1, 8'hC2);
        step(1'b1, 8'hC3);
        step(1'b1, 8'hC4);
        chk("pp_c4_count", 64'(o_count), 64'd3);
        repeat (36) step(1'b0, 8'h00);
        chk("pp_c40_count", 64'(o_count), 64'd3);
        step(1'b1, 8'hC5);
        chk("pp_c41_count", 64'(o_count), 64'd3);
        chk("pp_c41_ovf",   64'(o_overflow), 64'd0);
        chk("pp_c41_ready", 64'(o_ready), 64'd1);
        wait_frames(base + 5, "pp_frames");
        if (rx_count >= base + 2)
            chk("pp_gap", 64'(frame_starts[base+1] - frame_starts[base]), 64'(FRAME));
        repeat (3) step(1'b0, 8'h00);

        // Reset during data bit 3 of 0x5A with two bytes queued
        base = rx_count;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        step(1'b1, 8'h5A);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        repeat (17) step(1'b0, 8'h00);
        chk("rmid_c19_tx",    64'(o_tx),    64'd1);
        chk("rmid_c19_count", 64'(o_count), 64'd2);
        chk("rmid_c19_busy",  64'(o_busy),  64'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        chk("rmid_tx",    64'(o_tx),       64'd1);
        chk("rmid_count", 64'(o_count),    64'd0);
        chk("rmid_busy",  64'(o_busy),     64'd0);
        chk("rmid_ready", 64'(o_ready),    64'd1);
        chk("rmid_ovf",   64'(o_overflow), 64'd0);
        repeat (2) step(1'b0, 8'h00);
        chk("rmid_still_idle", 64'(o_tx), 64'd1);
        exp_q.push_back(8'h33);
        step(1'b1, 8'h33);
        pcyc = cyc;
        wait_frames(base + 1, "rmid_new_frame");
        if (rx_count > base)
            chk("rmid_new_start", 64'(frame_starts[base]), 64'(pcyc + 2));
        repeat (3) step(1'b0, 8'h00);
        chk("final_busy", 64'(o_busy), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
